// File: rtl/serial_term_tx.sv
// serial_term_tx: FIFO-buffered 8N1/8N2 serial transmitter for the Altair console rx pin.
// One down-counter times every start, data, stop and gap period and reloads at each boundary.
module serial_term_tx #(
  parameter int CLOCK      = 50000000,
  parameter int BAUD       = 19200,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_CYCLES = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  data_in,
  input  logic                        wr,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow,
  output logic                        busy,
  output logic                        tx
);

  localparam int DIV      = (CLOCK + BAUD / 2) / BAUD;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int PW       = AW + 1;
  localparam int STOP_LEN = STOP_BITS * DIV;
  localparam int MAX_A    = (DIV > GAP_CYCLES) ? DIV : GAP_CYCLES;
  localparam int MAX_CNT  = (MAX_A > 2 * DIV) ? MAX_A : 2 * DIV;
  localparam int CW       = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(DIV - 1);
  localparam logic [CW-1:0] STOP_LOAD = CW'(STOP_LEN - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW-1:0] LVL_FULL  = PW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q, wptr_d, rptr_d;
  logic [PW-1:0] level_q, level_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          overflow_q;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q, busy_q;

  logic          push_s, pop_s, frame_end_s;
  logic [7:0]    head_s;

  assign push_s = wr && !full_q;
  assign head_s = mem_q[rptr_q[AW-1:0]];
  assign pop_s  = !empty_q && ((state_q == S_IDLE) || frame_end_s);

  // Last cycle of a frame: end of the stop bits when there is no gap, else end of the gap.
  always_comb begin
    frame_end_s = 1'b0;
    case (state_q)
      S_STOP:  frame_end_s = (cnt_q == CNT_ZERO) && (GAP_CYCLES == 0);
      S_GAP:   frame_end_s = (cnt_q == CNT_ZERO);
      default: frame_end_s = 1'b0;
    endcase
  end

  // Next pointer values and the occupancy flags derived from them.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_s) begin
      wptr_d = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + PTR_ONE;
    end else begin
      rptr_d = rptr_q;
    end
    level_d = wptr_d - rptr_d;
    full_d  = (level_d == LVL_FULL);
    empty_d = (level_d == {PW{1'b0}});
  end

  // Character storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wptr_q[AW-1:0]] <= data_in;
    end
  end

  // FIFO pointers, registered status flags and the dropped-write pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= {PW{1'b0}};
      rptr_q     <= {PW{1'b0}};
      level_q    <= {PW{1'b0}};
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= wr && full_q;
    end
  end

  // Frame sequencer; a pop at IDLE or frame end overrides the case result and starts a new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_ZERO;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
        end
        S_START: begin
          if (cnt_q == CNT_ZERO) begin
            state_q <= S_DATA;
            cnt_q   <= BIT_LOAD;
            tx_q    <= shift_q[0];
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_ZERO) begin
            if (bit_q == 3'd7) begin
              state_q <= S_STOP;
              cnt_q   <= STOP_LOAD;
              tx_q    <= 1'b1;
            end else begin
              shift_q <= {1'b0, shift_q[7:1]};
              bit_q   <= bit_q + 3'd1;
              cnt_q   <= BIT_LOAD;
              tx_q    <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_STOP: begin
          if (cnt_q == CNT_ZERO) begin
            if (GAP_CYCLES > 0) begin
              state_q <= S_GAP;
              cnt_q   <= GAP_LOAD;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_GAP: begin
          if (cnt_q == CNT_ZERO) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
      if (pop_s) begin
        state_q <= S_START;
        cnt_q   <= BIT_LOAD;
        bit_q   <= 3'd0;
        shift_q <= head_s;
        tx_q    <= 1'b0;
        busy_q  <= 1'b1;
      end
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;
  assign overflow = overflow_q;
  assign busy     = busy_q;
  assign tx       = tx_q;

endmodule

// File: tb/tb_serial_term_tx.sv
// Bench for serial_term_tx: two instances (8N1 no gap, 8N2 with gap) checked every cycle
// against a frame-timeline model, plus hand-computed waveform points.
module tb_serial_term_tx;

  localparam int CLK_HZ  = 1000;
  localparam int BAUD_A  = 80;
  localparam int BAUD_B  = 100;
  localparam int STOP_A  = 1;
  localparam int STOP_B  = 2;
  localparam int DEPTH_A = 16;
  localparam int DEPTH_B = 4;
  localparam int GAP_A   = 0;
  localparam int GAP_B   = 7;
  localparam int DIV_A   = (CLK_HZ + BAUD_A / 2) / BAUD_A;
  localparam int DIV_B   = (CLK_HZ + BAUD_B / 2) / BAUD_B;
  localparam int LW_A    = $clog2(DEPTH_A) + 1;
  localparam int LW_B    = $clog2(DEPTH_B) + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [7:0]      data_a = 8'd0, data_b = 8'd0;
  logic            wr_a = 1'b0, wr_b = 1'b0;
  logic            full_a, empty_a, ovf_a, busy_a, tx_a;
  logic            full_b, empty_b, ovf_b, busy_b, tx_b;
  logic [LW_A-1:0] level_a;
  logic [LW_B-1:0] level_b;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  serial_term_tx #(.CLOCK(CLK_HZ), .BAUD(BAUD_A), .STOP_BITS(STOP_A),
                   .FIFO_DEPTH(DEPTH_A), .GAP_CYCLES(GAP_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .data_in(data_a), .wr(wr_a), .full(full_a),
    .empty(empty_a), .level(level_a), .overflow(ovf_a), .busy(busy_a), .tx(tx_a));

  serial_term_tx #(.CLOCK(CLK_HZ), .BAUD(BAUD_B), .STOP_BITS(STOP_B),
                   .FIFO_DEPTH(DEPTH_B), .GAP_CYCLES(GAP_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .data_in(data_b), .wr(wr_b), .full(full_b),
    .empty(empty_b), .level(level_b), .overflow(ovf_b), .busy(busy_b), .tx(tx_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int p_div(input int i);   return (i == 0) ? DIV_A : DIV_B;     endfunction
  function automatic int p_stop(input int i);  return (i == 0) ? STOP_A : STOP_B;   endfunction
  function automatic int p_gap(input int i);   return (i == 0) ? GAP_A : GAP_B;     endfunction
  function automatic int p_depth(input int i); return (i == 0) ? DEPTH_A : DEPTH_B; endfunction

  // Model: a queue of bytes and, while active, the cycle offset m_t within the current frame.
  logic [7:0] m_buf [2][16];
  int         m_cnt [2] = '{0, 0};
  bit         m_act [2] = '{1'b0, 1'b0};
  int         m_t   [2] = '{0, 0};
  logic [7:0] m_cur [2] = '{8'd0, 8'd0};
  bit         m_ovf [2] = '{1'b0, 1'b0};

  task automatic model_step(input int i, input bit w, input logic [7:0] d);
    int flen;
    bit full_before;
    bit do_pop;
    flen        = (9 + p_stop(i)) * p_div(i) + p_gap(i);
    full_before = (m_cnt[i] == p_depth(i));
    do_pop      = (m_cnt[i] > 0) && (!m_act[i] || (m_t[i] == flen - 1));
    if (do_pop) begin
      m_cur[i] = m_buf[i][0];
      for (int k = 0; k < 15; k++) m_buf[i][k] = m_buf[i][k + 1];
      m_cnt[i]--;
      m_act[i] = 1'b1;
      m_t[i]   = 0;
    end else if (m_act[i]) begin
      if (m_t[i] == flen - 1) m_act[i] = 1'b0;
      else m_t[i]++;
    end
    m_ovf[i] = w && full_before;
    if (w && !full_before) begin
      m_buf[i][m_cnt[i]] = d;
      m_cnt[i]++;
    end
  endtask

  function automatic int exp_tx(input int i);
    int bitn;
    if (!m_act[i]) return 1;
    bitn = m_t[i] / p_div(i);
    if (bitn == 0) return 0;
    if (bitn <= 8) return int'(m_cur[i][bitn - 1]);
    return 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_cnt[i] = 0;
        m_act[i] = 1'b0;
        m_t[i]   = 0;
        m_ovf[i] = 1'b0;
      end
    end else begin
      model_step(0, wr_a, data_a);
      model_step(1, wr_b, data_b);
    end
  end

  // Compare process: every output of both instances, every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      check("tx_a", int'(tx_a), exp_tx(0));
      check("busy_a", int'(busy_a), int'(m_act[0]));
      check("level_a", int'(level_a), m_cnt[0]);
      check("full_a", int'(full_a), int'(m_cnt[0] == DEPTH_A));
      check("empty_a", int'(empty_a), int'(m_cnt[0] == 0));
      check("overflow_a", int'(ovf_a), int'(m_ovf[0]));
      check("tx_b", int'(tx_b), exp_tx(1));
      check("busy_b", int'(busy_b), int'(m_act[1]));
      check("level_b", int'(level_b), m_cnt[1]);
      check("full_b", int'(full_b), int'(m_cnt[1] == DEPTH_B));
      check("empty_b", int'(empty_b), int'(m_cnt[1] == 0));
      check("overflow_b", int'(ovf_b), int'(m_ovf[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  initial begin
    int f;
    int exp41 [10] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1};

    // Reset, then idle.
    repeat (5) tick();
    check("rst_tx", int'(tx_a), 1);
    check("rst_empty", int'(empty_a), 1);
    check("rst_busy", int'(busy_b), 0);
    #1 rst_n = 1'b1;
    repeat (100) tick();
    check("idle_tx", int'(tx_a), 1);
    check("idle_level", int'(level_a), 0);

    // Single byte 0x41: two-cycle latency, LSB-first bits, 10-bit frame.
    wr_a = 1'b1; data_a = 8'h41; tick();
    check("wr_level", int'(level_a), 1);
    check("wr_tx_high", int'(tx_a), 1);
    wr_a = 1'b0; tick();
    check("start_tx_low", int'(tx_a), 0);
    check("start_busy", int'(busy_a), 1);
    check("start_level", int'(level_a), 0);
    f = cyc;
    for (int k = 0; k < 10; k++) begin
      wait_until(f + DIV_A / 2 + k * DIV_A);
      check($sformatf("bit%0d", k), int'(tx_a), exp41[k]);
    end
    while (busy_a && cyc < f + 200) tick();
    check("frame_len", cyc - f, 130);

    // Back-to-back 0x55, 0xAA: next start right after the last stop cycle.
    wr_a = 1'b1; data_a = 8'h55; tick();
    check("b2b_level1", int'(level_a), 1);
    data_a = 8'hAA; tick();
    wr_a = 1'b0;
    check("b2b_level_pop", int'(level_a), 1);
    f = cyc;
    wait_until(f + 129);
    check("b2b_last_stop", int'(tx_a), 1);
    tick();
    check("b2b_second_start", int'(tx_a), 0);
    check("b2b_busy", int'(busy_a), 1);
    while (busy_a && cyc < f + 400) tick();
    check("b2b_len", cyc - f, 260);

    // Full and overflow: one frame in flight, then 17 writes.
    wr_a = 1'b1; data_a = 8'($urandom); tick();
    wr_a = 1'b0; tick();
    f = cyc;
    for (int n = 0; n < 17; n++) begin
      wr_a = 1'b1; data_a = 8'($urandom); tick();
      if (n == 15) check("full_after_16", int'(full_a), 1);
      if (n == 16) begin
        check("ovf_pulse", int'(ovf_a), 1);
        check("ovf_level", int'(level_a), 16);
      end
    end
    wr_a = 1'b0; tick();
    check("ovf_one_cycle", int'(ovf_a), 0);
    while (busy_a && cyc < f + 17 * 130 + 100) tick();
    check("full_frames_len", cyc - f, 17 * 130);

    // Two stop bits plus a 7-cycle gap on instance B.
    wr_b = 1'b1; data_b = 8'h01; tick();
    data_b = 8'hC3; tick();
    wr_b = 1'b0;
    f = cyc;
    check("gap_start", int'(tx_b), 0);
    wait_until(f + 15);  check("gap_bit0", int'(tx_b), 1);
    wait_until(f + 85);  check("gap_bit7", int'(tx_b), 0);
    wait_until(f + 95);  check("gap_stop1", int'(tx_b), 1);
    wait_until(f + 105); check("gap_stop2", int'(tx_b), 1);
    wait_until(f + 116); check("gap_idle", int'(tx_b), 1);
    check("gap_busy", int'(busy_b), 1);
    tick();              check("gap_second_start", int'(tx_b), 0);
    while (busy_b && cyc < f + 400) tick();
    check("gap_len", cyc - f, 234);

    // Random traffic on both instances; the compare process does the checking.
    for (int n = 0; n < 2500; n++) begin
      wr_a = ($urandom_range(0, 7) == 0);
      data_a = 8'($urandom);
      wr_b = ($urandom_range(0, 5) == 0);
      data_b = 8'($urandom);
      tick();
    end
    wr_a = 1'b0; wr_b = 1'b0;
    f = cyc;
    while ((busy_a || busy_b || !empty_a || !empty_b) && cyc < f + 4000) tick();
    check("drain_done", int'(busy_a || busy_b), 0);

    // Reset during data bit 3 with 3 bytes queued.
    wr_a = 1'b1; data_a = 8'h00; tick();
    data_a = 8'h5A; tick();
    f = cyc;
    data_a = 8'h3C; tick();
    data_a = 8'hFF; tick();
    wr_a = 1'b0;
    check("mid_level", int'(level_a), 3);
    wait_until(f + 4 * DIV_A + 6);
    check("mid_tx_low", int'(tx_a), 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_tx", int'(tx_a), 1);
    check("mid_rst_level", int'(level_a), 0);
    check("mid_rst_busy", int'(busy_a), 0);
    check("mid_rst_empty", int'(empty_a), 1);
    repeat (3) tick();
    #1 rst_n = 1'b1;
    repeat (4 * 130) tick();
    check("post_rst_tx", int'(tx_a), 1);
    check("post_rst_busy", int'(busy_a), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
